// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB camera register loader.
package sccb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DELAY,
        START,
        SHIFT,
        STOP,
        FINISH
    } state_t;

    localparam logic [15:0] CMD_END       = 16'hFFFF;
    localparam logic [7:0]  CMD_DELAY_REG = 8'hFE;

    localparam int unsigned BITS_PER_BYTE = 9;
    localparam int unsigned BYTES_PER_TXN = 3;
    localparam int unsigned START_QTICKS  = 2;
    localparam int unsigned STOP_QTICKS   = 7;

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit tick divider: one-cycle qtick every DIV clocks, held at phase 0 while clr.
module sccb_tick_gen #(
    parameter int unsigned DIV = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic qtick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt   <= '0;
            qtick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt   <= '0;
            qtick <= 1'b1;
        end else begin
            cnt   <= cnt + CW'(1);
            qtick <= 1'b0;
        end
    end

endmodule

// File: rtl/sccb_cfg_engine.sv
// SCCB register loader: walks a {reg_addr, reg_data} table and writes each entry
// to the sensor as a 3-byte SCCB write, with ACK retry, table delays and status.
module sccb_cfg_engine
    import sccb_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned SCCB_HZ   = 100_000,
    parameter logic [7:0]  DEV_ADDR  = 8'h60,
    parameter int unsigned ROM_AW    = 8,
    parameter int unsigned NUM_CMDS  = 20,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned MS_CYC    = CLK_HZ / 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sioc,
    output logic              siod_oe,
    input  logic              siod_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] err_index
);

    localparam int unsigned Q_RAW   = CLK_HZ / (4 * SCCB_HZ);
    localparam int unsigned Q       = (Q_RAW == 0) ? 1 : Q_RAW;
    localparam int unsigned RW      = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [3:0]  ACK_BIT = 4'(BITS_PER_BYTE - 1);

    state_t          state;
    logic            qtick;
    logic            fetch_wait;
    logic [7:0]      reg_a;
    logic [7:0]      reg_d;
    logic [7:0]      sh;
    logic [31:0]     dly_cnt;
    logic [2:0]      qph;
    logic [3:0]      bit_idx;
    logic [1:0]      byte_idx;
    logic [RW-1:0]   retry;
    logic            nack;

    sccb_tick_gen #(
        .DIV(Q)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (~busy),
        .qtick(qtick)
    );

    // Saturates at NUM_CMDS so the end-of-table check can never be skipped.
    function automatic logic [ROM_AW-1:0] next_addr(input logic [ROM_AW-1:0] a);
        return (a == ROM_AW'(NUM_CMDS)) ? a : a + ROM_AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sioc       <= 1'b1;
            siod_oe    <= 1'b0;
            rom_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_index  <= '0;
            fetch_wait <= 1'b0;
            reg_a      <= '0;
            reg_d      <= '0;
            sh         <= '0;
            dly_cnt    <= '0;
            qph        <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            retry      <= '0;
            nack       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        rom_addr   <= '0;
                        fetch_wait <= 1'b0;
                        state      <= FETCH;
                    end
                end

                FETCH: begin
                    fetch_wait <= 1'b1;
                    if (fetch_wait) begin
                        fetch_wait <= 1'b0;
                        reg_a      <= rom_data[15:8];
                        reg_d      <= rom_data[7:0];
                        if (rom_addr == ROM_AW'(NUM_CMDS) || rom_data == CMD_END) begin
                            state <= FINISH;
                        end else if (rom_data[15:8] == CMD_DELAY_REG) begin
                            if (rom_data[7:0] == 8'd0) begin
                                rom_addr <= next_addr(rom_addr);
                            end else begin
                                dly_cnt <= 32'(rom_data[7:0]) * MS_CYC - 32'd1;
                                state   <= DELAY;
                            end
                        end else begin
                            retry <= '0;
                            qph   <= '0;
                            nack  <= 1'b0;
                            state <= START;
                        end
                    end
                end

                DELAY: begin
                    if (dly_cnt == 32'd0) begin
                        rom_addr <= next_addr(rom_addr);
                        state    <= FETCH;
                    end else begin
                        dly_cnt <= dly_cnt - 32'd1;
                    end
                end

                START: begin
                    if (qtick) begin
                        if (qph != 3'(START_QTICKS - 1)) begin
                            siod_oe <= 1'b1;
                            qph     <= qph + 3'd1;
                        end else begin
                            sioc     <= 1'b0;
                            qph      <= '0;
                            bit_idx  <= '0;
                            byte_idx <= '0;
                            sh       <= DEV_ADDR;
                            nack     <= 1'b0;
                            state    <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    if (qtick) begin
                        qph <= qph + 3'd1;
                        case (qph[1:0])
                            2'd0: siod_oe <= (bit_idx == ACK_BIT) ? 1'b0 : ~sh[7];
                            2'd1: sioc <= 1'b1;
                            2'd2: if (bit_idx == ACK_BIT && siod_in) nack <= 1'b1;
                            2'd3: begin
                                sioc <= 1'b0;
                                qph  <= '0;
                                if (bit_idx == ACK_BIT) begin
                                    bit_idx <= '0;
                                    if (nack || byte_idx == 2'(BYTES_PER_TXN - 1)) begin
                                        state <= STOP;
                                    end else begin
                                        byte_idx <= byte_idx + 2'd1;
                                        sh       <= (byte_idx == 2'd0) ? reg_a : reg_d;
                                    end
                                end else begin
                                    bit_idx <= bit_idx + 4'd1;
                                    sh      <= {sh[6:0], 1'b0};
                                end
                            end
                        endcase
                    end
                end

                // Stop condition, then bus-free time before the next attempt or entry.
                STOP: begin
                    if (qtick) begin
                        qph <= qph + 3'd1;
                        case (qph)
                            3'd0: siod_oe <= 1'b1;
                            3'd1: sioc    <= 1'b1;
                            3'd2: siod_oe <= 1'b0;
                            3'(STOP_QTICKS - 1): begin
                                qph <= '0;
                                if (!nack) begin
                                    rom_addr <= next_addr(rom_addr);
                                    state    <= FETCH;
                                end else if (retry == RW'(MAX_RETRY)) begin
                                    error     <= 1'b1;
                                    err_index <= rom_addr;
                                    busy      <= 1'b0;
                                    state     <= IDLE;
                                end else begin
                                    retry <= retry + RW'(1);
                                    nack  <= 1'b0;
                                    state <= START;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
